instr_fetch_unit: RTL and testbench

Fetch stage that drives the program ROM address and registers the returned instruction into a valid/ready output slot for the decode stage. Holds the PC, advances it by 4 per accepted fetch, and accepts branch/jump redirects from downstream. The ROM is combinational: data for rom_addr_out is valid in the same cycle.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_out_slot.sv | 38 +++
 rtl/instr_fetch_unit.sv | 89 ++++++++
 tb/tb_instr_fetch_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] pc_t;
    typedef logic [DATA_W-1:0] instr_t;

    typedef enum logic {
        RUN,
        HALT
    } fetch_state_e;

    // An all-zero word is what an unprogrammed ROM location reads as
    localparam instr_t ILLEGAL_INSTR = 32'h0;

endpackage

// File: rtl/fetch_out_slot.sv
// Single-entry valid/ready output register holding a fetched instruction and its PC.
module fetch_out_slot #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              flush,
    input  logic              out_ready,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    assign in_ready = !out_valid || out_ready;

    // Flush only empties the slot; a transfer in the same cycle has already completed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_instr <= in_instr;
            out_pc    <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, RUN/HALT FSM and registered output slot toward decode.
// Define FETCH_PERF_CNT_EN to add the saturating fetch/stall performance counters.
module instr_fetch_unit #(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                DATA_W   = fetch_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr_out,
    input  logic [DATA_W-1:0] rom_data_in,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_fetch_cnt,
    output logic [15:0]       perf_stall_cnt
`endif
);

    import fetch_pkg::*;

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic              slot_free;
    logic              rom_zero;
    logic              capture;

    assign rom_addr_out = pc;
    assign rom_zero     = (rom_data_in == DATA_W'(ILLEGAL_INSTR));
    assign capture      = (state == RUN) && slot_free && !redirect_valid && !rom_zero;

    // Redirect wins over everything; a zero word halts instead of being captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            state  <= RUN;
            pc     <= redirect_pc & ~ADDR_W'(3);
            halted <= 1'b0;
        end else if (state == RUN && slot_free) begin
            if (rom_zero) begin
                state  <= HALT;
                halted <= 1'b1;
            end else begin
                pc <= pc + ADDR_W'(4);
            end
        end
    end

    fetch_out_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (capture),
        .in_instr  (rom_data_in),
        .in_pc     (pc),
        .flush     (redirect_valid),
        .out_ready (out_ready),
        .in_ready  (slot_free),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pc    (out_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (capture && perf_fetch_cnt != 16'hFFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            if (out_valid && !out_ready && perf_stall_cnt != 16'hFFFF)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stimulus, expected transfers queued, monitor compares.
module tb_instr_fetch_unit;

    typedef struct {
        logic [3:0]  pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [3:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [3:0]  out_pc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt;
    logic [15:0] perf_stall_cnt;
`endif

    logic [31:0] rom [0:15];
    exp_t        exp_q[$];
    int          checks;
    int          errors;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr_out   (rom_addr),
        .rom_data_in    (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic rv, input logic [3:0] rpc);
        @(posedge clk);
        #2;
        out_ready      = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic pushExp(input logic [3:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    // Monitor: every handshake seen at the falling edge must match the oldest queued entry
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_transfer: got pc 0x%0h instr 0x%0h, expected none", out_pc, out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    errors++;
                    $display("[TB] FAIL transfer: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
        rom[0]  = 32'h44216a93;
        rom[4]  = 32'h65125748;
        rom[8]  = 32'hffb00193;
        rom[12] = 32'h156778dc;
        rst            = 1'b1;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 4'h0;

        @(negedge clk);
        checkOutput("reset_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("reset_halted", {31'b0, halted}, 32'h0);
        checkOutput("reset_addr", {28'b0, rom_addr}, 32'h0);
        checkOutput("reset_instr", out_instr, 32'h0);
        checkOutput("reset_pc", {28'b0, out_pc}, 32'h0);

        // Sequential fetch with wrap, then a stall holding the entry from address 4
        pushExp(4'h0, 32'h44216a93);
        pushExp(4'h4, 32'h65125748);
        pushExp(4'h8, 32'hffb00193);
        pushExp(4'hC, 32'h156778dc);
        pushExp(4'h0, 32'h44216a93);
        pushExp(4'h4, 32'h65125748);
        pushExp(4'h8, 32'hffb00193);

        @(posedge clk);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        #3;
        checkOutput("release_valid", {31'b0, out_valid}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 4'h0);
            if (i == 0) begin
                #3;
                checkOutput("first_valid", {31'b0, out_valid}, 32'h1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'h0);
            #3;
            checkOutput("stall_valid", {31'b0, out_valid}, 32'h1);
            checkOutput("stall_instr", out_instr, 32'h65125748);
            checkOutput("stall_pc", {28'b0, out_pc}, 32'h4);
            checkOutput("stall_addr", {28'b0, rom_addr}, 32'h8);
        end
        applyStimulus(1'b1, 1'b0, 4'h0);
        #3;
        checkOutput("release_pc", {28'b0, out_pc}, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_stall", {16'b0, perf_stall_cnt}, 32'd3);
        checkOutput("perf_fetch", {16'b0, perf_fetch_cnt}, 32'd6);
`endif

        // Redirect to 0xE alongside an accepted transfer of the entry from 8
        pushExp(4'hC, 32'h156778dc);
        pushExp(4'h0, 32'h44216a93);
        pushExp(4'h4, 32'h65125748);
        applyStimulus(1'b1, 1'b1, 4'hE);
        #3;
        checkOutput("after_stall_pc", {28'b0, out_pc}, 32'h8);
        applyStimulus(1'b1, 1'b0, 4'h0);
        #3;
        checkOutput("bubble_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("bubble_addr", {28'b0, rom_addr}, 32'hC);
        applyStimulus(1'b1, 1'b0, 4'h0);
        rom[8] = 32'h0;
        #3;
        checkOutput("target_pc", {28'b0, out_pc}, 32'hC);
        checkOutput("target_instr", out_instr, 32'h156778dc);

        // Zero word at 8 halts the unit; redirect to 0 resumes
        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b1, 1'b0, 4'h0);
        #3;
        checkOutput("halt_flag", {31'b0, halted}, 32'h1);
        checkOutput("halt_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("halt_addr", {28'b0, rom_addr}, 32'h8);
        pushExp(4'h0, 32'h44216a93);
        applyStimulus(1'b1, 1'b1, 4'h0);
        #3;
        checkOutput("halt_hold", {31'b0, halted}, 32'h1);
        applyStimulus(1'b1, 1'b0, 4'h0);
        #3;
        checkOutput("resume_halted", {31'b0, halted}, 32'h0);
        checkOutput("resume_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("resume_addr", {28'b0, rom_addr}, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0);
        #3;
        checkOutput("resume_pc", {28'b0, out_pc}, 32'h0);

        // Asynchronous reset in the middle of a stall
        applyStimulus(1'b0, 1'b0, 4'h0);
        #3;
        checkOutput("pre_reset_valid", {31'b0, out_valid}, 32'h1);
        checkOutput("pre_reset_pc", {28'b0, out_pc}, 32'h4);
        applyStimulus(1'b0, 1'b0, 4'h0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_valid", {31'b0, out_valid}, 32'h0);
        checkOutput("async_halted", {31'b0, halted}, 32'h0);
        checkOutput("async_addr", {28'b0, rom_addr}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("async_perf_fetch", {16'b0, perf_fetch_cnt}, 32'd0);
        checkOutput("async_perf_stall", {16'b0, perf_stall_cnt}, 32'd0);
`endif
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
